// File: rtl/miner_wrapper.sv
// miner_wrapper: UART echo/shift link, free-running nonce and 8-digit hex display for the miner board
// Ports: clk, reset (async, active-high); rxd/txd 8N1 UART, idle high;
//        display_toggle selects data_word/nonce/byte_count/err_count; an/ca drive the active-low display.
module miner_wrapper #(
  parameter int CLKS_PER_BIT = 868,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] ca,
  output logic [7:0] an,
  output logic       txd,
  input  logic       rxd,
  input  logic [3:0] display_toggle
);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] REF_LAST = 32'(REFRESH_DIV - 1);
  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  logic        rx_meta = 1'b1;
  logic        rx_sync = 1'b1;
  rx_state_t   rx_state = RX_IDLE;
  rx_state_t   rx_next;
  logic [15:0] rx_cnt = '0;
  logic [15:0] rx_cnt_n;
  logic [2:0]  rx_bit = '0;
  logic [2:0]  rx_bit_n;
  logic [7:0]  rx_shift = '0;
  logic [7:0]  rx_shift_n;
  logic        byte_valid = 1'b0;
  logic        byte_valid_n;
  logic [7:0]  err_count = '0;
  logic [7:0]  err_count_n;
  tx_state_t   tx_state = TX_IDLE;
  tx_state_t   tx_next;
  logic [15:0] tx_cnt = '0;
  logic [15:0] tx_cnt_n;
  logic [2:0]  tx_bit = '0;
  logic [2:0]  tx_bit_n;
  logic [7:0]  tx_shift = '0;
  logic [7:0]  tx_shift_n;
  logic        tx_start;
  logic        txd_q = 1'b1;
  logic        txd_n;
  logic        hold_valid = 1'b0;
  logic [7:0]  hold_byte = '0;
  logic [31:0] data_word = '0;
  logic [31:0] nonce = '0;
  logic [15:0] byte_count = '0;
  logic [31:0] snapshot = '0;
  logic [31:0] ref_cnt = '0;
  logic [2:0]  dig = '0;
  logic        ref_wrap;
  logic [31:0] disp_sel;
  assign txd = txd_q;
  assign ref_wrap = ref_cnt == REF_LAST;
  assign an = ~(8'h01 << dig);
  assign ca = GLYPH[snapshot[{dig, 2'b00} +: 4]];
  assign disp_sel = display_toggle == 4'd0 ? data_word :
                    display_toggle == 4'd1 ? nonce :
                    display_toggle == 4'd2 ? {16'h0, byte_count} :
                    display_toggle == 4'd3 ? {24'h0, err_count} : 32'h0;
  always_comb begin
    rx_next = rx_state;
    rx_cnt_n = rx_cnt + 16'd1;
    rx_bit_n = rx_bit;
    rx_shift_n = rx_shift;
    byte_valid_n = 1'b0;
    err_count_n = err_count;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_sync) rx_next = RX_START;
      end
      RX_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        rx_next = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n = '0;
        rx_shift_n = {rx_sync, rx_shift[7:1]};
        rx_bit_n = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n = '0;
        byte_valid_n = rx_sync;
        err_count_n = err_count + {7'd0, !rx_sync && err_count != 8'hFF};
        rx_next = rx_sync ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: begin
        rx_cnt_n = '0;
        if (rx_sync) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end
  always_comb begin
    tx_next = tx_state;
    tx_cnt_n = tx_cnt + 16'd1;
    tx_bit_n = tx_bit;
    tx_shift_n = tx_shift;
    tx_start = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (hold_valid) begin
          tx_next = TX_START;
          tx_shift_n = hold_byte;
          tx_start = 1'b1;
        end
      end
      TX_START: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        tx_bit_n = '0;
        tx_next = TX_DATA;
      end
      TX_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        tx_shift_n = {1'b0, tx_shift[7:1]};
        tx_bit_n = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_next = TX_STOP;
      end
      TX_STOP: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
    // txd is registered from the next state so the line never glitches
    txd_n = tx_next == TX_START ? 1'b0 : tx_next == TX_DATA ? tx_shift_n[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_shift <= '0;
      byte_valid <= 1'b0;
      err_count <= '0;
      tx_state <= TX_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_shift <= '0;
      txd_q <= 1'b1;
    end else begin
      rx_state <= rx_next;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_shift <= rx_shift_n;
      byte_valid <= byte_valid_n;
      err_count <= err_count_n;
      tx_state <= tx_next;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd_q <= txd_n;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      nonce <= '0;
      data_word <= '0;
      byte_count <= '0;
      hold_valid <= 1'b0;
      hold_byte <= '0;
      ref_cnt <= '0;
      dig <= '0;
      snapshot <= '0;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      nonce <= nonce + 32'd1;
      if (byte_valid) data_word <= {data_word[23:0], rx_shift};
      if (byte_valid) byte_count <= byte_count + 16'd1;
      // a fresh byte wins over the clear caused by a transmit starting the same cycle
      hold_valid <= byte_valid | (hold_valid & ~tx_start);
      if (byte_valid) hold_byte <= rx_shift;
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 32'd1;
      if (ref_wrap) dig <= dig + 3'd1;
      if (ref_wrap && dig == 3'd7) snapshot <= disp_sel;
    end
endmodule

// File: tb/tb_miner_wrapper.sv
// tb_miner_wrapper: randomized UART/display stimulus with queue-based scoreboard for miner_wrapper
`timescale 1ns/1ps
module tb_miner_wrapper;
  localparam int CPB = 8;
  localparam int RD = 4;
  localparam logic [7:0] GLY [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  typedef struct {
    time         t;
    bit          nonce;
    logic [31:0] val;
  } disp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic txd;
  logic [7:0] ca, an;
  logic [3:0] display_toggle = 4'd0;
  int checks = 0;
  int errors = 0;
  disp_t disp_q[$];
  logic [7:0] tx_q[$];
  logic [31:0] dw = '0;
  logic [15:0] bc = '0;
  logic [7:0] ec = '0;
  logic [31:0] edges = '0;
  miner_wrapper #(.CLKS_PER_BIT(CPB), .REFRESH_DIV(RD)) dut (
    .clk(clk),
    .reset(reset),
    .ca(ca),
    .an(an),
    .txd(txd),
    .rxd(rxd),
    .display_toggle(display_toggle)
  );
  always #5 clk = ~clk;
  // clock edges seen since reset release: the value the nonce must hold
  always @(posedge clk or posedge reset) edges <= reset ? 32'd0 : edges + 32'd1;
  function automatic logic [4:0] decode(input logic [7:0] c);
    decode = 5'h10;
    for (int i = 0; i < 16; i++) if (c == GLY[i]) decode = {1'b0, 4'(i)};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic uart_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      tick(CPB);
    end
    rxd = 1'b1;
    tick(2 * CPB);
  endtask
  task automatic send_byte(input logic [7:0] b, input bit echo);
    if (echo) tx_q.push_back(b);
    uart_send(b, 1'b1);
    dw = {dw[23:0], b};
    bc = bc + 16'd1;
  endtask
  task automatic drain_tx();
    int n = 0;
    while (tx_q.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    if (tx_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL tx_drain: %0d echoes outstanding, expected 0", tx_q.size());
      tx_q.delete();
    end
    tick(4);
  endtask
  task automatic disp_req(input logic [3:0] tog, input bit nonce, input logic [31:0] val, input int cnt);
    disp_t e;
    int n = 0;
    display_toggle = tog;
    e.t = $time;
    e.nonce = nonce;
    e.val = val;
    for (int i = 0; i < cnt; i++) disp_q.push_back(e);
    while (disp_q.size() != 0 && n < 40 * RD * cnt) begin
      tick(1);
      n++;
    end
    if (disp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL disp_timeout: toggle %0d has %0d scans pending, expected 0", tog, disp_q.size());
      disp_q.delete();
    end
  endtask
  // TX monitor: decodes each frame at mid-bit and pops the expected echo
  logic [9:0] fr;
  logic [7:0] exp_b;
  bit ab;
  initial forever begin
    @(negedge clk);
    if (!reset && txd === 1'b0) begin
      ab = 1'b0;
      for (int k = 0; k < CPB / 2; k++) begin
        @(negedge clk);
        ab |= reset;
      end
      fr[0] = txd;
      for (int i = 1; i < 10; i++) begin
        for (int k = 0; k < CPB; k++) begin
          @(negedge clk);
          ab |= reset;
        end
        fr[i] = txd;
      end
      if (!ab) begin
        checks++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_frame: unexpected frame %b, expected none", fr);
        end else begin
          exp_b = tx_q.pop_front();
          if (fr !== {1'b1, exp_b, 1'b0}) begin
            errors++;
            $display("FAIL tx_frame: got %b expected %b", fr, {1'b1, exp_b, 1'b0});
          end
        end
      end
    end
  end
  // display monitor: rebuilds the shown word from each full scan and pops the expected value
  logic [7:0] prev_an = 8'hFE;
  logic [7:0] want_an;
  logic [4:0] dec;
  logic [31:0] snap = '0, wrap_edges = '0, last_nonce = '0, exp_v;
  int nd = 0;
  int dwell = 0;
  bit scan_on = 1'b0, scan_bad = 1'b0, have_last = 1'b0;
  time scan_t = 0, last_t = 0;
  disp_t de;
  always @(negedge clk) begin
    dwell++;
    if (reset) begin
      scan_on = 1'b0;
      have_last = 1'b0;
    end else if (an != prev_an) begin
      if (an == 8'hFE) begin
        scan_on = 1'b1;
        nd = 0;
        scan_bad = 1'b0;
        scan_t = $time - 5;
        wrap_edges = edges;
      end else if (scan_on) begin
        nd++;
        if (dwell != RD) scan_bad = 1'b1;
      end
      if (scan_on) begin
        want_an = ~(8'h01 << nd);
        dec = decode(ca);
        if (an != want_an || dec[4]) scan_bad = 1'b1;
        snap[4*nd +: 4] = dec[3:0];
        if (nd == 7) begin
          scan_on = 1'b0;
          if (disp_q.size() != 0 && disp_q[0].t < scan_t) begin
            de = disp_q.pop_front();
            exp_v = de.nonce ? wrap_edges - 32'd1 : de.val;
            checks++;
            if (scan_bad || snap !== exp_v) begin
              errors++;
              $display("FAIL display_scan: toggle %0d shows %h (scan_err %0d) expected %h", display_toggle, snap, scan_bad, exp_v);
            end
            if (de.nonce && have_last && scan_t - last_t == 8 * RD * 10) begin
              checks++;
              if (snap - last_nonce !== 32'(8 * RD)) begin
                errors++;
                $display("FAIL nonce_step: got %0d expected %0d", snap - last_nonce, 8 * RD);
              end
            end
            have_last = de.nonce;
            last_nonce = snap;
            last_t = scan_t;
          end
        end
      end
      dwell = 0;
    end
    prev_an = an;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [7:0] b;
    int bad;
    int n;
    #1;
    check("rst_txd", txd, 1);
    check("rst_an", an, 8'hFE);
    check("rst_ca", ca, 8'hC0);
    tick(3);
    reset = 1'b0;
    disp_req(4'd0, 1'b0, 32'h0, 1);
    send_byte(8'hA5, 1'b1);
    drain_tx();
    disp_req(4'd0, 1'b0, dw, 1);
    disp_req(4'd2, 1'b0, {16'h0, bc}, 1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    drain_tx();
    disp_req(4'd0, 1'b0, 32'h12345678, 1);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
    drain_tx();
    disp_req(4'd0, 1'b0, dw, 1);
    disp_req(4'd2, 1'b0, {16'h0, bc}, 1);
    uart_send(8'($urandom), 1'b0);
    ec = ec == 8'hFF ? ec : ec + 8'd1;
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(4 * CPB);
    disp_req(4'd3, 1'b0, {24'h0, ec}, 1);
    disp_req(4'd2, 1'b0, {16'h0, bc}, 1);
    disp_req(4'(4 + $urandom_range(0, 11)), 1'b0, 32'h0, 1);
    disp_req(4'd1, 1'b1, 32'h0, 3);
    reset = 1'b1;
    rxd = 1'b0;
    tick(3);
    reset = 1'b0;
    dw = '0;
    bc = '0;
    ec = 8'd1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (txd !== 1'b1) bad++;
    end
    check("break_txd_idle", bad, 0);
    disp_req(4'd3, 1'b0, {24'h0, ec}, 1);
    disp_req(4'd2, 1'b0, {16'h0, bc}, 1);
    rxd = 1'b1;
    tick(4);
    send_byte(8'h00, 1'b1);
    drain_tx();
    disp_req(4'd2, 1'b0, {16'h0, bc}, 1);
    disp_req(4'd3, 1'b0, {24'h0, ec}, 1);
    b = 8'($urandom) & 8'hEF;
    send_byte(b, 1'b0);
    n = 0;
    while (txd !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    check("echo_start_seen", {31'h0, txd}, 32'h0);
    tick(44);
    check("tx_bit4_low", txd, 0);
    #1 reset = 1'b1;
    #1;
    check("midtx_txd", txd, 1);
    check("midtx_an", an, 8'hFE);
    check("midtx_ca", ca, 8'hC0);
    tick(3);
    reset = 1'b0;
    dw = '0;
    bc = '0;
    ec = '0;
    disp_req(4'd0, 1'b0, dw, 1);
    disp_req(4'd2, 1'b0, {16'h0, bc}, 1);
    disp_req(4'd3, 1'b0, {24'h0, ec}, 1);
    disp_req(4'd1, 1'b1, 32'h0, 2);
    drain_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/miner_wrapper.md
# miner_wrapper

FPGA top-level for the bitcoin-miner board. Ties a UART link (rxd/txd), a 32-bit free-running nonce counter and an 8-digit multiplexed seven-segment display into one block. Received bytes are echoed back and shifted into a data word. A 4-bit switch input selects which internal value is shown on the display.

## Interface
- CLKS_PER_BIT, default 868: clocks per UART bit (100 MHz / 115200 baud).
- REFRESH_DIV, default 100000: clocks each display digit stays enabled.
- clk  input  1: single system clock, 100 MHz, rising edge.
- reset  input  1: asynchronous, active-high; clears all state.
- ca  output  8: segment cathodes, active-low. ca[0..6] = segments a..g, ca[7] = decimal point.
- an  output  8: digit anodes, active-low. an[i] enables digit i; digit 0 is rightmost.
- txd  output  1: UART transmit, 8N1, idle high.
- rxd  input  1: UART receive, 8N1, asynchronous to clk.
- display_toggle  input  4: display source select.

## Operation
- Power-up: every register has an initial value equal to its reset value, so the block is deterministic before the first reset.
- rxd passes through a 2-FF synchronizer; all RX logic uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE -> START: on synchronized rxd = 0.
  - START: sample at CLKS_PER_BIT/2. If rxd = 1, treat as a glitch and go to IDLE; otherwise go to DATA.
  - DATA: 8 samples, one every CLKS_PER_BIT, LSB first.
  - STOP: sample the stop bit. If 1, raise a one-cycle byte_valid and go to IDLE. If 0, it is a framing error: err_count += 1 (saturates at 255), no byte is delivered, go to BREAK.
  - BREAK: stay until rxd = 1, then go to IDLE.
- On byte_valid:
  - data_word <= {data_word[23:0], byte}.
  - byte_count (16 bits) += 1, wrapping at 0xFFFF -> 0.
  - The byte is loaded into a one-entry echo holding register. A byte arriving while the holding register is full overwrites it.
- TX FSM states: IDLE, START, DATA, STOP, each bit lasting CLKS_PER_BIT clocks.
  - Starts when idle and the holding register is valid.
  - Sends the start bit (0), 8 data bits LSB first, then the stop bit (1).
  - The holding register is cleared when transmission starts.
- nonce: 32 bits, increments every clock, wraps from 0xFFFFFFFF to 0.
- Display source select:
  - display_toggle = 0: data_word.
  - 1: nonce.
  - 2: {16'h0, byte_count}.
  - 3: {24'h0, err_count}.
  - 4–15: 32'h0.
- Display snapshot: the selected value is copied into a snapshot register when the digit index wraps to 0, and at reset. The displayed value never tears mid-scan.
- Digit scan:
  - Digit index advances 0 -> 7 -> 0 every REFRESH_DIV clocks.
  - an = ~(1 << index).
  - ca[6:0] shows the hex glyph of snapshot nibble [4*index+3 : 4*index]; ca[7] = 1 (decimal point always off).
- Glyphs (ca, 0–F): C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.

## Timing
- Reset values:
  - txd = 1, an = 8'hFE, ca = 8'hC0.
  - data_word, nonce, byte_count, err_count and snapshot all 0.
  - RX/TX FSMs IDLE; digit index 0; refresh counter 0.
- Reset mid-frame: an RX or TX frame is abandoned immediately (asynchronous); txd goes to 1 without waiting for a clock.
- RX latency:
  - byte_valid asserts in the cycle after the stop-bit sample.
  - data_word and byte_count are updated on the next edge.
- Echo: txd falls (start bit) no more than 2 clocks after byte_valid when TX is idle. A full frame is 10*CLKS_PER_BIT clocks.
- rxd held low from power-up/reset: exactly one framing error per low period, then BREAK. No further bytes until rxd has been high for at least one synchronized cycle.
- Changing display_toggle takes effect at the next digit-0 wrap, i.e. within 8*REFRESH_DIV clocks.
- Simultaneous byte_valid and TX start: the load into the holding register wins. The new byte is sent in the following frame.

## Test plan
- Release reset, rxd = 1, toggle = 0, REFRESH_DIV = 4 -> txd stays 1, ca = C0 on all digits, an cycles FE, FD, FB, F7, EF, DF, BF, 7F every 4 clocks.
- CLKS_PER_BIT = 8; send byte 0xA5 -> byte_count = 1, data_word = 0x000000A5, txd replays the frame 0, 1,0,1,0,0,1,0,1, 1.
- Send 12, 34, 56, 78, toggle = 0 -> data_word = 0x12345678, digit 7 ca = F9, digit 0 ca = 80.
- Hold rxd = 0 through and after reset -> err_count = 1, byte_count = 0, txd stays 1. Raise rxd, send 0x00 -> byte_count = 1.
- toggle = 1 -> snapshot equals nonce at each digit-0 wrap; successive snapshots differ by 8*REFRESH_DIV (mod 2^32).
- Assert reset during bit 4 of a TX echo -> txd = 1 immediately, all counters 0, an = FE, ca = C0.
